// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Covers the controller state encoding, register addresses and a generic enable flag.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      S_INIT      = 2'd0,
      S_RUN       = 2'd1,
      S_DMEM_WAIT = 2'd2,
      S_IDROP     = 2'd3
   } ctrl_state_t;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic {
      EN_OFF = 1'b0,
      EN_ON  = 1'b1
   } enable_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: flags a load in EX whose non-zero rd feeds a source register read in ID.
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic      i_id_uses_rs1,
   input  logic      i_id_uses_rs2,
   input  reg_addr_t i_id_rs1,
   input  reg_addr_t i_id_rs2,
   input  reg_addr_t i_ex_rd,
   input  logic      i_ex_mem_read,
   output enable_t   o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

   // x0 is never a true dependency
   assign o_load_use = (i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit))
                       ? EN_ON : EN_OFF;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: reset flush, data-memory wait,
// stale-fetch discard after redirects, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int INIT_FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH         = 32
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           id_rs1_i,
   input  logic [4:0]           id_rs2_i,
   input  logic                 id_uses_rs1_i,
   input  logic                 id_uses_rs2_i,
   input  logic [4:0]           ex_rd_i,
   input  logic                 ex_mem_read_i,
   input  logic                 ex_redirect_i,
   input  logic                 imem_ready_i,
   input  logic                 dmem_req_i,
   input  logic                 dmem_ready_i,
   output logic                 pc_we_o,
   output logic                 if2id_stall_o,
   output logic                 if2id_flush_o,
   output logic                 id2ex_stall_o,
   output logic                 id2ex_flush_o,
   output logic                 ex2mem_stall_o,
   output logic                 ex2mem_flush_o,
   output logic                 mem2wb_flush_o,
   output logic [1:0]           state_o,
   output logic [CNT_WIDTH-1:0] stall_cycles_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   localparam logic [3:0] INIT_LAST = 4'(INIT_FLUSH_CYCLES - 1);

   ctrl_state_t          r_state;
   ctrl_state_t          w_state_next;
   logic [3:0]           r_init_cnt;
   logic                 r_drop;
   logic                 w_drop_next;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;
   enable_t              w_load_use;
   logic                 w_dmem_busy;
   logic                 w_redirect_taken;
   logic                 w_stall_event;

   pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
      .i_id_uses_rs1 (id_uses_rs1_i),
      .i_id_uses_rs2 (id_uses_rs2_i),
      .i_id_rs1      (id_rs1_i),
      .i_id_rs2      (id_rs2_i),
      .i_ex_rd       (ex_rd_i),
      .i_ex_mem_read (ex_mem_read_i),
      .o_load_use    (w_load_use)
   );

   assign w_dmem_busy = dmem_req_i && !dmem_ready_i;

   // r_drop survives a data-memory wait so the stale fetch is still discarded afterwards
   always_comb begin
      pc_we_o          = 1'b0;
      if2id_stall_o    = 1'b0;
      if2id_flush_o    = 1'b0;
      id2ex_stall_o    = 1'b0;
      id2ex_flush_o    = 1'b0;
      ex2mem_stall_o   = 1'b0;
      ex2mem_flush_o   = 1'b0;
      mem2wb_flush_o   = 1'b0;
      w_state_next     = r_state;
      w_drop_next      = r_drop;
      w_redirect_taken = 1'b0;

      if (r_state == S_INIT) begin
         if2id_flush_o  = 1'b1;
         id2ex_flush_o  = 1'b1;
         ex2mem_flush_o = 1'b1;
         mem2wb_flush_o = 1'b1;
         w_drop_next    = 1'b0;
         if (r_init_cnt == INIT_LAST) begin
            w_state_next = S_RUN;
         end
      end else if (w_dmem_busy) begin
         if2id_stall_o  = 1'b1;
         id2ex_stall_o  = 1'b1;
         ex2mem_stall_o = 1'b1;
         mem2wb_flush_o = 1'b1;
         w_state_next   = S_DMEM_WAIT;
      end else if (r_drop) begin
         if2id_flush_o = 1'b1;
         if (ex_redirect_i) begin
            pc_we_o          = 1'b1;
            id2ex_flush_o    = 1'b1;
            w_redirect_taken = 1'b1;
            w_state_next     = S_IDROP;
         end else if (imem_ready_i) begin
            pc_we_o      = 1'b1;
            w_drop_next  = 1'b0;
            w_state_next = S_RUN;
         end else begin
            w_state_next = S_IDROP;
         end
      end else begin
         w_state_next = S_RUN;
         if (ex_redirect_i) begin
            pc_we_o          = 1'b1;
            if2id_flush_o    = 1'b1;
            id2ex_flush_o    = 1'b1;
            w_redirect_taken = 1'b1;
            if (!imem_ready_i) begin
               w_drop_next  = 1'b1;
               w_state_next = S_IDROP;
            end
         end else if (w_load_use == EN_ON) begin
            if2id_stall_o = 1'b1;
            id2ex_flush_o = 1'b1;
         end else if (!imem_ready_i) begin
            if2id_flush_o = 1'b1;
         end else begin
            pc_we_o = 1'b1;
         end
      end
   end

   assign w_stall_event = !pc_we_o && ((r_state == S_RUN) || (r_state == S_DMEM_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_init_cnt  <= 4'd0;
         r_drop      <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_drop  <= w_drop_next;
         if ((r_state == S_INIT) && (r_init_cnt != INIT_LAST)) begin
            r_init_cnt <= r_init_cnt + 4'd1;
         end
         if (w_stall_event && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_redirect_taken && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign state_o        = r_state;
   assign stall_cycles_o = r_stall_cnt;
   assign flush_count_o  = r_flush_cnt;

endmodule
